cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Multi-cycle controller FSM that sequences the team's 16-bit register/shifter/ALU datapath for the reduced instruction set (MOV imm, MOV reg, ADD, CMP, AND, MVN).
- Accepts one instruction per start pulse and latches it in an internal instruction register.
- Decodes the instruction and drives every datapath strobe and select, one datapath step per cycle.
- Sits between the instruction source and the datapath; w tells the source when the next instruction may be issued.

Parameters:
- DW, 16, datapath word width; sximm8 width.
- IW, 16, instruction width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- s  in  1  start; sampled only in WAIT.
- instr  in  IW  instruction; captured on the clk edge where s=1 in WAIT.
- w  out  1  idle/ready; 1 iff state==WAIT.
- readnum  out  3  register file read index.
- writenum  out  3  register file write index.
- write  out  1  register file write enable.
- loada  out  1  A register enable.
- loadb  out  1  B register enable.
- asel  out  1  1 = zero into ALU A input.
- bsel  out  1  1 = sximm into ALU B input.
- loadc  out  1  C register enable.
- loads  out  1  status register enable.
- vsel  out  4  one-hot writeback source: 0001 mdata, 0010 sximm8, 0100 PC, 1000 C.
- shift  out  2  shifter op.
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B.
- sximm8  out  DW  sign-extended ir[7:0].

Behaviour:
- Encoding:
  - ir[15:13] opcode; ir[12:11] op; ir[10:8] Rn; ir[7:5] Rd; ir[4:3] sh; ir[2:0] Rm; ir[7:0] imm8.
  - Legal pairs: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm,sh; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN.
- States: WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM.
- Reset:
  - reset_n=0 at a clk edge → state=WAIT and ir=0.
  - Every strobe (write, loada, loadb, loadc, loads) = 0; asel=bsel=0; vsel=0000; readnum=writenum=shift=ALUop=0; w=1.
  - Reset wins over every other event, including mid-instruction. The abandoned instruction produces no further strobes.
- WAIT:
  - All strobes 0 and w=1.
  - s=1 → ir<=instr, next state DECODE. s=0 → stay in WAIT.
  - s is ignored in every state other than WAIT.
- DECODE:
  - No strobes asserted.
  - MOV imm → WR_IMM. ADD, CMP, AND → GET_A. MOV reg, MVN → GET_B. Illegal opcode/op → WAIT with no side effects.
- GET_A: readnum=Rn, loada=1 → GET_B.
- GET_B: readnum=Rm, loadb=1 → ALU.
- ALU:
  - shift=sh, bsel=0.
  - MOV reg: asel=1, ALUop=00.
  - Other ops: asel=0, ALUop=op.
  - CMP: loads=1, loadc=0 → WAIT.
  - Others: loadc=1 → WR_REG.
- WR_REG: writenum=Rd, vsel=1000, write=1 → WAIT.
- WR_IMM: writenum=Rn, vsel=0010, write=1 → WAIT.
- Outputs:
  - All outputs are decoded from state and ir (Moore); no combinational path from s or instr to any strobe.
  - readnum, writenum, shift, ALUop, vsel, asel, bsel = 0 in any state not listed above for that signal.
- sximm8 = {{8{ir[7]}}, ir[7:0]}, valid in every state.
- Latency: cycles from the accept edge until w returns to 1:
  - MOV imm 2.
  - MOV reg, MVN 4.
  - ADD, AND 5.
  - CMP 4.
  - Illegal 1.
- Back-to-back: if s=1 on the first WAIT cycle, the next instruction is accepted on that edge, so WAIT lasts exactly 1 cycle.
- Exactly one of loada, loadb, loadc, loads, write is high in any cycle, or none.

Decomposition:
- cpu_pkg:
  - State enum (3-bit).
  - Opcode/op constants.
  - VSEL_MDATA/VSEL_IMM/VSEL_PC/VSEL_C one-hot constants.
  - ALU op constants.
- Sub-module instr_dec: combinational field extraction, legality check, sximm8. The FSM, ir register and output decode live in cpu_controller.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset_n=0 with s=1 for 3 cycles, then release with s=0.
  - Required: w=1 throughout; all strobes 0 throughout; no state advance.
- MOV imm:
  - Stimulus: instr=0xD5FF (MOV R5,#-1), pulse s.
  - Required: 2 cycles later WR_IMM with writenum=5, vsel=0010, write=1, sximm8=0xFFFF.
  - Required: w=1 on the following cycle.
- ADD with shift:
  - Stimulus: instr=0xA148 (ADD R2,R1,R0,LSL#1).
  - Required per cycle: GET_A readnum=1 loada=1; GET_B readnum=0 loadb=1; ALU shift=01 ALUop=00 asel=0 bsel=0 loadc=1; WR_REG writenum=2 vsel=1000 write=1.
  - Required: w low for exactly 5 cycles.
- CMP, MVN, MOV reg:
  - Stimulus CMP: 0xA801 (CMP R0,R1). Required: ALU with ALUop=01, loads=1, loadc=0, write never asserted; 4 cycles.
  - Stimulus MVN: 0xB860 (MVN R3,R0). Required: no GET_A; ALUop=11; writenum=3.
  - Stimulus MOV reg: 0xC081 (MOV R4,R1). Required: asel=1, ALUop=00, writenum=4.
- Illegal and mid-op events:
  - Stimulus: instr=0xE000. Required: back to WAIT after DECODE, zero strobes.
  - Stimulus: ADD in flight, reset_n=0 during GET_B. Required: next cycle WAIT, write never asserted.
  - Stimulus: change instr and toggle s mid-op. Required: ir is unchanged.
- Back-to-back:
  - Stimulus: s held high with 0xD007 then 0xD102.
  - Required: writes to R0 (sximm8=0x0007) then R1 (sximm8=0x0002); single-cycle WAIT between them.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the reduced-instruction-set controller: FSM state
// encoding, opcode/op field values, one-hot writeback select codes and ALU
// operation codes. Imported by instr_dec and cpu_controller.
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Controller FSM states. WAIT is encoded as zero.
  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_ALU    = 3'd4,
    S_WR_REG = 3'd5,
    S_WR_IMM = 3'd6
  } state_t;

  // Opcode field ir[15:13]
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  // Op field ir[12:11] within each opcode class
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // One-hot writeback source select
  localparam logic [3:0] VSEL_NONE  = 4'b0000;
  localparam logic [3:0] VSEL_MDATA = 4'b0001;
  localparam logic [3:0] VSEL_IMM   = 4'b0010;
  localparam logic [3:0] VSEL_PC    = 4'b0100;
  localparam logic [3:0] VSEL_C     = 4'b1000;

  // ALU operations
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// ---------------------------------------------------------------------------
// instr_dec
// Purely combinational decode of the latched instruction register.
// Ports:
//   ir          in   16   latched instruction
//   rn, rd, rm  out  3    register index fields
//   sh          out  2    shifter op field
//   alu_sel     out  2    ALU op to use in the ALU step
//   is_mov_imm  out  1    MOV Rn,#imm8
//   is_mov_reg  out  1    MOV Rd,Rm,sh
//   is_cmp      out  1    CMP (status only, no writeback)
//   uses_rn     out  1    instruction reads Rn into A (ADD/CMP/AND)
//   legal       out  1    opcode/op pair is one of the six supported
//   sximm8      out  DW   sign-extended ir[7:0]
// ---------------------------------------------------------------------------
module instr_dec
  import cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [15:0]   ir,
  output logic [2:0]    rn,
  output logic [2:0]    rd,
  output logic [2:0]    rm,
  output logic [1:0]    sh,
  output logic [1:0]    alu_sel,
  output logic          is_mov_imm,
  output logic          is_mov_reg,
  output logic          is_cmp,
  output logic          uses_rn,
  output logic          legal,
  output logic [DW-1:0] sximm8
);

  logic [2:0] opcode;
  logic [1:0] op;
  logic       alu_class;
  logic       mov_class;

  // Field extraction; the imm8 field overlaps Rd/sh/Rm by design.
  always_comb begin
    opcode = ir[15:13];
    op     = ir[12:11];
    rn     = ir[10:8];
    rd     = ir[7:5];
    sh     = ir[4:3];
    rm     = ir[2:0];
    sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
  end

  // Classification. Every op value is legal under the ALU opcode, while
  // only two of the four are legal under the MOV opcode. MOV reg reuses
  // the adder with A forced to zero, so its ALU op is always ADD.
  always_comb begin
    alu_class  = (opcode == OPC_ALU);
    mov_class  = (opcode == OPC_MOV);
    is_mov_imm = mov_class && (op == OP_MOV_IMM);
    is_mov_reg = mov_class && (op == OP_MOV_REG);
    is_cmp     = alu_class && (op == OP_CMP);
    uses_rn    = alu_class && (op != OP_MVN);
    legal      = alu_class || is_mov_imm || is_mov_reg;
    alu_sel    = is_mov_reg ? ALU_ADD : op;
  end

endmodule

// File: rtl/cpu_controller.sv
// ---------------------------------------------------------------------------
// cpu_controller
// Multi-cycle Moore controller for the 16-bit register/shifter/ALU datapath.
// Latches one instruction per start pulse and steps the datapath through
// read A, read B, ALU and writeback, one step per cycle.
// Ports:
//   clk       in   1    rising-edge clock
//   reset_n   in   1    synchronous active-low reset
//   s         in   1    start, only looked at in WAIT
//   instr     in   IW   instruction, captured when accepted
//   w         out  1    high while idle in WAIT
//   readnum   out  3    register file read index
//   writenum  out  3    register file write index
//   write     out  1    register file write enable
//   loada     out  1    A register enable
//   loadb     out  1    B register enable
//   asel      out  1    zero into ALU A input
//   bsel      out  1    sximm into ALU B input
//   loadc     out  1    C register enable
//   loads     out  1    status register enable
//   vsel      out  4    one-hot writeback source
//   shift     out  2    shifter op
//   ALUop     out  2    ALU op
//   sximm8    out  DW   sign-extended ir[7:0]
// ---------------------------------------------------------------------------
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s,
  input  logic [IW-1:0] instr,
  output logic          w,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          asel,
  output logic          bsel,
  output logic          loadc,
  output logic          loads,
  output logic [3:0]    vsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [DW-1:0] sximm8
);

  state_t        state;
  state_t        next_state;
  logic [IW-1:0] ir;

  logic [2:0] rn;
  logic [2:0] rd;
  logic [2:0] rm;
  logic [1:0] sh;
  logic [1:0] alu_sel;
  logic       is_mov_imm;
  logic       is_mov_reg;
  logic       is_cmp;
  logic       uses_rn;
  logic       legal;

  instr_dec #(
    .DW(DW)
  ) u_dec (
    .ir         (ir[15:0]),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm),
    .sh         (sh),
    .alu_sel    (alu_sel),
    .is_mov_imm (is_mov_imm),
    .is_mov_reg (is_mov_reg),
    .is_cmp     (is_cmp),
    .uses_rn    (uses_rn),
    .legal      (legal),
    .sximm8     (sximm8)
  );

  // State and instruction register. The instruction is only captured on
  // the accept edge so it stays stable for the whole multi-cycle sequence.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_WAIT && s) begin
        ir <= instr;
      end
    end
  end

  // Next-state logic. MVN and MOV reg skip the A read since they never use
  // Rn; illegal encodings fall straight back to WAIT from DECODE.
  always_comb begin
    next_state = state;
    case (state)
      S_WAIT:   next_state = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (is_mov_imm)   next_state = S_WR_IMM;
        else if (uses_rn) next_state = S_GET_A;
        else if (legal)   next_state = S_GET_B;
        else              next_state = S_WAIT;
      end
      S_GET_A:  next_state = S_GET_B;
      S_GET_B:  next_state = S_ALU;
      S_ALU:    next_state = is_cmp ? S_WAIT : S_WR_REG;
      S_WR_REG: next_state = S_WAIT;
      S_WR_IMM: next_state = S_WAIT;
      default:  next_state = S_WAIT;
    endcase
  end

  // Moore output decode from state and ir only, so nothing on s or instr
  // can reach a strobe combinationally. At most one enable is raised per
  // state.
  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    vsel     = VSEL_NONE;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    case (state)
      S_WAIT:   w = 1'b1;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = sh;
        asel  = is_mov_reg;
        ALUop = alu_sel;
        if (is_cmp) loads = 1'b1;
        else        loadc = 1'b1;
      end
      S_WR_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
      end
      S_WR_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_controller
// Self-checking bench for cpu_controller. Expected per-cycle output vectors
// are queued as each instruction is issued and popped at every falling edge.
// ---------------------------------------------------------------------------
module tb_cpu_controller;

  logic        clk;
  logic        reset_n;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loadc;
  logic        loads;
  logic [3:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;

  cpu_controller #(
    .DW(16),
    .IW(16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .instr    (instr),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .asel     (asel),
    .bsel     (bsel),
    .loadc    (loadc),
    .loads    (loads),
    .vsel     (vsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic [3:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
    logic [15:0] sximm8;
  } out_t;

  typedef struct {
    logic [15:0] instr;
    int          latency;
  } vec_t;

  out_t        exp_q[$];
  int          checks;
  int          errors;
  int          wlow;
  logic [15:0] model_ir;

  // Idle vector: WAIT outputs plus the sign extension of the held ir
  function automatic out_t idleVec(input logic [15:0] ir);
    out_t v;
    v        = '0;
    v.w      = 1'b1;
    v.sximm8 = {{8{ir[7]}}, ir[7:0]};
    return v;
  endfunction

  function automatic out_t busyVec(input logic [15:0] ir);
    out_t v;
    v   = idleVec(ir);
    v.w = 1'b0;
    return v;
  endfunction

  // Queue the cycle-by-cycle outputs expected after an accept edge
  task automatic pushInstrSeq(input logic [15:0] ir);
    out_t       v;
    logic [2:0] opc;
    logic [1:0] op;
    logic       mov_reg;
    logic       mvn;
    logic       cmp;
    opc     = ir[15:13];
    op      = ir[12:11];
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    mvn     = (opc == 3'b101) && (op == 2'b11);
    cmp     = (opc == 3'b101) && (op == 2'b01);
    exp_q.push_back(busyVec(ir));
    if (opc == 3'b110 && op == 2'b10) begin
      v          = busyVec(ir);
      v.writenum = ir[10:8];
      v.vsel     = 4'b0010;
      v.write    = 1'b1;
      exp_q.push_back(v);
    end else if (opc == 3'b101 || mov_reg) begin
      if (!mov_reg && !mvn) begin
        v         = busyVec(ir);
        v.readnum = ir[10:8];
        v.loada   = 1'b1;
        exp_q.push_back(v);
      end
      v         = busyVec(ir);
      v.readnum = ir[2:0];
      v.loadb   = 1'b1;
      exp_q.push_back(v);
      v        = busyVec(ir);
      v.shift  = ir[4:3];
      v.asel   = mov_reg;
      v.alu_op = mov_reg ? 2'b00 : op;
      if (cmp) v.loads = 1'b1;
      else     v.loadc = 1'b1;
      exp_q.push_back(v);
      if (!cmp) begin
        v          = busyVec(ir);
        v.writenum = ir[7:5];
        v.vsel     = 4'b1000;
        v.write    = 1'b1;
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic applyStimulus(input logic s_val, input logic [15:0] instr_val);
    s     = s_val;
    instr = instr_val;
  endtask

  // Compare one cycle at the falling edge, then step to just past the next
  // rising edge where new stimulus may be driven.
  task automatic checkOutput(input string name);
    out_t act;
    out_t exp;
    @(negedge clk);
    act = {w, readnum, writenum, write, loada, loadb, asel, bsel,
           loadc, loads, vsel, shift, ALUop, sximm8};
    if (act.w == 1'b0) wlow++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h required %h", name, act, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from WAIT and follow it back to WAIT
  task automatic runInstr(input logic [15:0] val, output int lat);
    exp_q.push_back(idleVec(model_ir));
    applyStimulus(1'b1, val);
    wlow = 0;
    checkOutput("accept");
    model_ir = val;
    applyStimulus(1'b0, 16'($urandom));
    pushInstrSeq(val);
    while (exp_q.size() > 0) checkOutput("seq");
    lat = wlow;
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  vec_t vecs[9];

  initial begin
    int lat;
    checks   = 0;
    errors   = 0;
    wlow     = 0;
    model_ir = 16'h0000;

    vecs[0] = '{16'hD5FF, 2};  // MOV R5,#-1
    vecs[1] = '{16'hA148, 5};  // ADD R2,R1,R0,LSL#1
    vecs[2] = '{16'hA801, 4};  // CMP R0,R1
    vecs[3] = '{16'hB860, 4};  // MVN R3,R0
    vecs[4] = '{16'hC081, 4};  // MOV R4,R1
    vecs[5] = '{16'hB2E9, 5};  // AND R7,R2,R1,LSL#1
    vecs[6] = '{16'hE000, 1};  // illegal opcode
    vecs[7] = '{16'hC800, 1};  // illegal MOV op 01
    vecs[8] = '{16'hD880, 1};  // illegal MOV op 11

    // Reset held with s asserted: must stay idle with ir cleared
    reset_n = 1'b0;
    applyStimulus(1'b1, 16'hD5FF);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(idleVec(16'h0000));
      checkOutput("reset_hold");
    end
    reset_n = 1'b1;
    applyStimulus(1'b0, 16'h0000);
    exp_q.push_back(idleVec(16'h0000));
    checkOutput("reset_release");

    // Table-driven instructions with latency check
    for (int i = 0; i < 9; i++) begin
      runInstr(vecs[i].instr, lat);
      checks++;
      if (lat != vecs[i].latency) begin
        errors++;
        $display("[TB] FAIL latency[%0d] %h: got %0d required %0d",
                 i, vecs[i].instr, lat, vecs[i].latency);
      end
    end

    // Reset during GET_B of an ADD abandons it without a write
    exp_q.push_back(idleVec(model_ir));
    applyStimulus(1'b1, 16'hA148);
    checkOutput("rst_accept");
    model_ir = 16'hA148;
    applyStimulus(1'b0, 16'h0000);
    pushInstrSeq(16'hA148);
    checkOutput("rst_decode");
    checkOutput("rst_get_a");
    reset_n = 1'b0;
    checkOutput("rst_get_b");
    exp_q.delete();
    model_ir = 16'h0000;
    exp_q.push_back(idleVec(16'h0000));
    checkOutput("rst_wait0");
    reset_n = 1'b1;
    exp_q.push_back(idleVec(16'h0000));
    checkOutput("rst_wait1");

    // s toggled and instr changed mid-instruction must not disturb ir
    exp_q.push_back(idleVec(model_ir));
    applyStimulus(1'b1, 16'hA148);
    wlow = 0;
    checkOutput("tog_accept");
    model_ir = 16'hA148;
    pushInstrSeq(16'hA148);
    while (exp_q.size() > 0) begin
      if (exp_q.size() > 1) applyStimulus(~s, 16'($urandom));
      else                  applyStimulus(1'b0, 16'hD5FF);
      checkOutput("toggle");
    end
    checks++;
    if (wlow != 5) begin
      errors++;
      $display("[TB] FAIL toggle_latency: got %0d required 5", wlow);
    end

    // Back-to-back MOV imm with s held high: single-cycle WAIT between
    exp_q.push_back(idleVec(model_ir));
    applyStimulus(1'b1, 16'hD007);
    checkOutput("b2b_accept0");
    model_ir = 16'hD007;
    applyStimulus(1'b1, 16'hD102);
    pushInstrSeq(16'hD007);
    while (exp_q.size() > 0) checkOutput("b2b_first");
    exp_q.push_back(idleVec(16'hD007));
    checkOutput("b2b_wait");
    model_ir = 16'hD102;
    applyStimulus(1'b0, 16'h0000);
    pushInstrSeq(16'hD102);
    while (exp_q.size() > 0) checkOutput("b2b_second");
    exp_q.push_back(idleVec(16'hD102));
    checkOutput("b2b_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
